// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl
// Issue controller in front of an FPUnit. It accepts one floating-point
// request at a time over a valid/ready handshake and drives the FPU operands
// and start level. When the FPU reports finish it captures the sum, waits for
// finish to drop, and returns the result over a second valid/ready handshake.
// Subtraction is done by flipping the sign of b. Reserved opcodes are rejected
// with an error response. Every FPU wait is bounded by TIMEOUT cycles.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_op                     00 add, 01 sub, 10 mul, 11 reserved
//   req_a, req_b               IEEE-754 single operands
//   res_valid/res_ready        result handshake
//   res_data, res_err          result word, error flag (timeout/reserved)
//   fpu_a, fpu_b               operands to the FPU
//   fpu_multiplicando          1 = multiply, 0 = add
//   fpu_start                  start level, held until finish or abort
//   fpu_s, fpu_finish          result and completion from the FPU
module fp_issue_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_multiplicando,
  output logic        fpu_start,
  input  logic [31:0] fpu_s,
  input  logic        fpu_finish
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [1:0]  OP_SUB   = 2'b01;
  localparam logic [1:0]  OP_MUL   = 2'b10;
  localparam logic [1:0]  OP_RSV   = 2'b11;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        accept_s;
  logic        cnt_last_s;

  // Negation of an IEEE-754 value is a flip of its sign bit.
  function automatic logic [31:0] flip_sign(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

  // Handshake decode and timeout compare.
  assign req_ready  = (state_r == IDLE);
  assign accept_s   = req_valid && req_ready;
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Controller FSM with all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      cnt_r             <= 16'd0;
      res_valid         <= 1'b0;
      res_data          <= 32'd0;
      res_err           <= 1'b0;
      fpu_a             <= 32'd0;
      fpu_b             <= 32'd0;
      fpu_multiplicando <= 1'b0;
      fpu_start         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            fpu_a             <= req_a;
            fpu_b             <= (req_op == OP_SUB) ? flip_sign(req_b) : req_b;
            fpu_multiplicando <= (req_op == OP_MUL);
            if (req_op == OP_RSV) begin
              // Rejected without touching the FPU.
              res_data  <= 32'd0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state_r   <= RESP;
            end else begin
              fpu_start <= 1'b1;
              cnt_r     <= 16'd0;
              state_r   <= ISSUE;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ISSUE: begin
          // A finish seen on the last allowed cycle still wins over timeout.
          if (fpu_finish) begin
            res_data  <= fpu_s;
            res_err   <= 1'b0;
            fpu_start <= 1'b0;
            cnt_r     <= 16'd0;
            state_r   <= DRAIN;
          end else if (cnt_last_s) begin
            res_data  <= QNAN;
            res_err   <= 1'b1;
            fpu_start <= 1'b0;
            cnt_r     <= 16'd0;
            state_r   <= DRAIN;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        DRAIN: begin
          // Let a lingering finish level drop so it cannot complete the next
          // operation; a stuck finish is bounded by the same timeout.
          if (!fpu_finish || cnt_last_s) begin
            cnt_r     <= 16'd0;
            res_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            res_valid <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          fpu_start <= 1'b0;
          res_valid <= 1'b0;
          cnt_r     <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Issue controller sitting directly upstream of `FPUnit`. It accepts floating-point requests from the integer pipeline over a valid/ready handshake and drives `FPUnit`'s `a`, `b`, `multiplicando` and `start`. It waits for `finish`, captures `s`, and returns the result over a second valid/ready handshake. It also implements subtraction by sign-flipping `b`, rejects reserved opcodes, and bounds every FPU operation with a timeout so a hung FPU cannot stall the core.

## Interface
Parameters:
- `TIMEOUT`, 1024: maximum cycles spent in ISSUE or in DRAIN before aborting. Legal range 2..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
- `req_a`, `req_b`  in  32  IEEE-754 single operands.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  32  result word.
- `res_err`  out  1  1 = timeout or reserved op.
- `fpu_a`, `fpu_b`  out  32  to `FPUnit` `a`/`b`.
- `fpu_multiplicando`  out  1  to `FPUnit` `multiplicando`: 1 = multiply, 0 = add.
- `fpu_start`  out  1  to `FPUnit` `start`; a level held until finish or abort.
- `fpu_s`  in  32  from `FPUnit` `s`.
- `fpu_finish`  in  1  from `FPUnit` `finish`.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP. 16-bit cycle counter `cnt`.
- All outputs except `req_ready` are registered. `req_ready` = (state == IDLE).
- **IDLE**, on accept (`req_valid && req_ready`):
  - `fpu_a` <= `req_a`.
  - For op 01: `fpu_b` <= {~`req_b`[31], `req_b`[30:0]}. Otherwise `fpu_b` <= `req_b`.
  - `fpu_multiplicando` <= (op == 10).
  - Op 11: `fpu_start` stays 0. `res_data` <= 0, `res_err` <= 1, go to RESP.
  - Ops 00/01/10: `fpu_start` <= 1, `cnt` <= 0, go to ISSUE.
- **ISSUE**, evaluated each cycle:
  - If `fpu_finish` = 1: `res_data` <= `fpu_s`, `res_err` <= 0, `fpu_start` <= 0, `cnt` <= 0, go to DRAIN.
  - Else if `cnt` == `TIMEOUT`-1: `res_data` <= 32'h7FC00000 (qNaN), `res_err` <= 1, `fpu_start` <= 0, `cnt` <= 0, go to DRAIN.
  - Otherwise `cnt` increments.
  - The finish check has priority over the timeout when both occur in the same cycle.
- **DRAIN**: waits for `fpu_finish` == 0, so a stale finish level cannot complete the next operation.
  - Leave for RESP when `fpu_finish` == 0 or `cnt` == `TIMEOUT`-1.
  - `res_data` and `res_err` are not modified in DRAIN.
- **RESP**: `res_valid` = 1.
  - `res_data` and `res_err` stay stable until `res_ready` is sampled high.
  - On that cycle `res_valid` <= 0 and the state returns to IDLE.
- `fpu_a`, `fpu_b` and `fpu_multiplicando` hold their values from accept until the next accept.
- Reset, at any time including mid-operation: the state returns to IDLE immediately and any in-flight result is discarded.

## Timing
- Reset values: state IDLE, `req_ready` 1, `res_valid` 0, `res_data` 0, `res_err` 0, `fpu_a` 0, `fpu_b` 0, `fpu_multiplicando` 0, `fpu_start` 0, `cnt` 0.
- Accept at edge T: `fpu_start` = 1 and the operands are valid after T.
- `fpu_finish` first sampled high at edge F: `fpu_start` = 0 after F, and `res_data` is captured at F.
- The earliest possible `res_valid` is 1 cycle after F, when `fpu_finish` is already low at F+1.
- Reserved op: `res_valid` = 1 one cycle after accept.
- Result accepted at edge R: `req_ready` = 1 after R. Back-to-back accept is possible at edge R+1.
- Throughput: at most one request in flight. No pipelining.
- Worst case from accept to `res_valid`: 2·`TIMEOUT`+1 cycles.

## Test plan
- **Add:** op 00, a=0x40200000 (2.5), b=0x40400000 (3.0), FPU model returns the correct sum.
  - Expect `fpu_multiplicando`=0, `fpu_b`=0x40400000.
  - Expect `res_data`=0x40B00000 (5.5), `res_err`=0.
- **Sub:** op 01, same operands.
  - Expect `fpu_b`=0xC0400000.
  - Expect `res_data`=0xBF000000 (-0.5), `res_err`=0.
- **Mul:** op 10, same operands, model finishes after 40 cycles.
  - Expect `fpu_multiplicando`=1 and `fpu_start` high for exactly 40 cycles.
  - Expect `res_data`=0x40F00000 (7.5).
  - Hold `res_ready`=0 for 5 cycles: `res_valid` and `res_data` stay stable throughout.
- **Timeout:** `TIMEOUT`=16, `fpu_finish` tied 0.
  - Expect `fpu_start` to fall after 16 cycles in ISSUE.
  - Expect `res_data`=0x7FC00000, `res_err`=1.
- **Reserved op:** op 11.
  - Expect `fpu_start` never asserted.
  - Expect `res_valid`=1 the cycle after accept, `res_data`=0, `res_err`=1.
- **Reset mid-operation:** assert `reset` while in ISSUE.
  - Expect `fpu_start`=0, `res_valid`=0, `req_ready`=1 immediately.
  - After release, a new add completes with the correct result.
